// File: rtl/ras_ctrl.sv
// ras_ctrl: fetch-side call/return pre-decode driving RAS push/pop and a registered return prediction
module ras_ctrl #(
  parameter int DATA_WIDTH  = 64,
  parameter int DATA_DEPTH  = 4,
  parameter int FETCH_WIDTH = 2,
  localparam int SW = (FETCH_WIDTH > 1) ? $clog2(FETCH_WIDTH) : 1,
  localparam int CW = $clog2(DATA_DEPTH + 1)
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    bp_flush_i,
  input  logic                    fetch_vld_i,
  output logic                    fetch_rdy_o,
  input  logic [DATA_WIDTH-1:0]   fetch_pc_i,
  input  logic [32*FETCH_WIDTH-1:0] fetch_instr_i,
  output logic                    ras_push_o,
  output logic                    ras_pop_o,
  output logic [DATA_WIDTH-1:0]   ras_data_o,
  input  logic                    ras_data_vld_i,
  input  logic [DATA_WIDTH-1:0]   ras_data_i,
  output logic                    pred_vld_o,
  input  logic                    pred_rdy_i,
  output logic                    pred_taken_o,
  output logic [DATA_WIDTH-1:0]   pred_target_o,
  output logic [SW-1:0]           pred_slot_o,
  output logic                    pred_call_o
);
  logic [CW-1:0] count;
  logic          hit, is_jal, rd_link, rs1_link, push_t, pop_t, accept;
  logic [SW-1:0] slot;
  logic [4:0]    rd, rs1;
  // pick the lowest slot holding JAL or JALR; scanning downward lets the lowest hit overwrite
  always_comb begin
    hit = 1'b0;
    is_jal = 1'b0;
    slot = '0;
    rd = '0;
    rs1 = '0;
    for (int i = FETCH_WIDTH - 1; i >= 0; i--) begin
      if (fetch_instr_i[32*i +: 7] == 7'b1101111 ||
          (fetch_instr_i[32*i +: 7] == 7'b1100111 && fetch_instr_i[32*i+12 +: 3] == 3'b000)) begin
        hit = 1'b1;
        is_jal = fetch_instr_i[32*i +: 7] == 7'b1101111;
        slot = SW'(i);
        rd = fetch_instr_i[32*i+7 +: 5];
        rs1 = fetch_instr_i[32*i+15 +: 5];
      end
    end
  end
  assign rd_link     = rd == 5'd1 || rd == 5'd5;
  assign rs1_link    = rs1 == 5'd1 || rs1 == 5'd5;
  assign push_t      = hit && rd_link;
  assign pop_t       = hit && !is_jal && rs1_link && (!rd_link || rd != rs1);
  assign fetch_rdy_o = !bp_flush_i && (!pred_vld_o || pred_rdy_i);
  assign accept      = rst_ni && fetch_vld_i && fetch_rdy_o;
  assign ras_push_o  = accept && push_t;
  assign ras_pop_o   = accept && pop_t && count != '0;
  assign ras_data_o  = fetch_pc_i + DATA_WIDTH'({slot, 2'b00}) + DATA_WIDTH'(4);
  // occupancy tracking: saturating push, pop-only decrement, pop+push holds
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) count <= '0;
    else if (bp_flush_i) count <= '0;
    else if (ras_push_o && !ras_pop_o && count != CW'(DATA_DEPTH)) count <= count + CW'(1);
    else if (ras_pop_o && !ras_push_o) count <= count - CW'(1);
  end
  // prediction record: loads on acceptance, drops when consumed, cleared by flush
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pred_vld_o    <= 1'b0;
      pred_taken_o  <= 1'b0;
      pred_target_o <= '0;
      pred_slot_o   <= '0;
      pred_call_o   <= 1'b0;
    end else if (bp_flush_i) begin
      pred_vld_o <= 1'b0;
    end else if (accept) begin
      pred_vld_o    <= 1'b1;
      pred_taken_o  <= ras_pop_o && ras_data_vld_i;
      pred_target_o <= (ras_pop_o && ras_data_vld_i) ? ras_data_i : '0;
      pred_slot_o   <= slot;
      pred_call_o   <= push_t;
    end else if (pred_rdy_i) begin
      pred_vld_o <= 1'b0;
    end
  end
endmodule

// File: tb/tb_ras_ctrl.sv
// tb_ras_ctrl: directed checks of ras_ctrl decode, RAS strobes, record timing, saturation and flush
module tb_ras_ctrl;
  localparam logic [31:0] ADDI   = 32'h0000_0013;
  localparam logic [31:0] JAL1   = 32'h1000_00EF;
  localparam logic [31:0] JAL0   = 32'h0000_006F;
  localparam logic [31:0] RET    = 32'h0000_8067;
  localparam logic [31:0] JR15   = 32'h0002_80E7;
  localparam logic [31:0] JR11   = 32'h0000_80E7;
  localparam logic [31:0] JRF3   = 32'h0000_10E7;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        bp_flush = 1'b0;
  logic        fetch_vld = 1'b0;
  logic        fetch_rdy;
  logic [63:0] fetch_pc = '0;
  logic [63:0] fetch_instr = '0;
  logic        ras_push, ras_pop;
  logic [63:0] ras_data;
  logic        ras_data_vld = 1'b0;
  logic [63:0] ras_top = '0;
  logic        pred_vld, pred_rdy = 1'b1, pred_taken, pred_call;
  logic [63:0] pred_target;
  logic [0:0]  pred_slot;
  int checks = 0;
  int failures = 0;
  always #5 clk = ~clk;
  ras_ctrl dut (
    .clk_i(clk), .rst_ni(rst_n), .bp_flush_i(bp_flush),
    .fetch_vld_i(fetch_vld), .fetch_rdy_o(fetch_rdy),
    .fetch_pc_i(fetch_pc), .fetch_instr_i(fetch_instr),
    .ras_push_o(ras_push), .ras_pop_o(ras_pop), .ras_data_o(ras_data),
    .ras_data_vld_i(ras_data_vld), .ras_data_i(ras_top),
    .pred_vld_o(pred_vld), .pred_rdy_i(pred_rdy), .pred_taken_o(pred_taken),
    .pred_target_o(pred_target), .pred_slot_o(pred_slot), .pred_call_o(pred_call)
  );
  task automatic drive(input logic [63:0] pc, input logic [31:0] s1, input logic [31:0] s0);
    @(negedge clk);
    fetch_pc = pc;
    fetch_instr = {s1, s0};
    fetch_vld = 1'b1;
    #1;
  endtask
  task automatic settle();
    @(posedge clk);
    #1;
    fetch_vld = 1'b0;
  endtask
  task automatic test_reset();
    rst_n = 1'b0;
    fetch_vld = 1'b1;
    fetch_instr = {ADDI, JAL1};
    repeat (2) @(negedge clk);
    #1;
    checks++; if (ras_push !== 1'b0) begin failures++; $display("FAIL reset_push got=%b exp=0", ras_push); end
    checks++; if (ras_pop !== 1'b0) begin failures++; $display("FAIL reset_pop got=%b exp=0", ras_pop); end
    checks++; if ({pred_vld, pred_taken, pred_call, pred_slot} !== 4'b0) begin failures++; $display("FAIL reset_flags got=%b exp=0000", {pred_vld, pred_taken, pred_call, pred_slot}); end
    checks++; if (pred_target !== 64'h0) begin failures++; $display("FAIL reset_target got=%h exp=0", pred_target); end
    checks++; if (dut.count !== 3'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", dut.count); end
    fetch_vld = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask
  task automatic test_call();
    drive(64'h1000, ADDI, JAL1);
    checks++; if (fetch_rdy !== 1'b1) begin failures++; $display("FAIL call_rdy got=%b exp=1", fetch_rdy); end
    checks++; if ({ras_push, ras_pop} !== 2'b10) begin failures++; $display("FAIL call_strobes got=%b exp=10", {ras_push, ras_pop}); end
    checks++; if (ras_data !== 64'h1004) begin failures++; $display("FAIL call_data got=%h exp=1004", ras_data); end
    settle();
    checks++; if ({pred_vld, pred_call, pred_slot, pred_taken} !== 4'b1100) begin failures++; $display("FAIL call_record got=%b exp=1100", {pred_vld, pred_call, pred_slot, pred_taken}); end
    checks++; if (dut.count !== 3'd1) begin failures++; $display("FAIL call_count got=%0d exp=1", dut.count); end
  endtask
  task automatic test_return();
    ras_data_vld = 1'b1;
    ras_top = 64'h1004;
    drive(64'h2000, RET, ADDI);
    checks++; if ({ras_push, ras_pop} !== 2'b01) begin failures++; $display("FAIL ret_strobes got=%b exp=01", {ras_push, ras_pop}); end
    settle();
    checks++; if ({pred_vld, pred_taken, pred_slot, pred_call} !== 4'b1110) begin failures++; $display("FAIL ret_record got=%b exp=1110", {pred_vld, pred_taken, pred_slot, pred_call}); end
    checks++; if (pred_target !== 64'h1004) begin failures++; $display("FAIL ret_target got=%h exp=1004", pred_target); end
    checks++; if (dut.count !== 3'd0) begin failures++; $display("FAIL ret_count got=%0d exp=0", dut.count); end
  endtask
  task automatic test_underflow();
    drive(64'h2100, ADDI, RET);
    checks++; if ({ras_push, ras_pop} !== 2'b00) begin failures++; $display("FAIL uf_strobes got=%b exp=00", {ras_push, ras_pop}); end
    settle();
    checks++; if ({pred_vld, pred_taken} !== 2'b10) begin failures++; $display("FAIL uf_record got=%b exp=10", {pred_vld, pred_taken}); end
    checks++; if (pred_target !== 64'h0) begin failures++; $display("FAIL uf_target got=%h exp=0", pred_target); end
    checks++; if (dut.count !== 3'd0) begin failures++; $display("FAIL uf_count got=%0d exp=0", dut.count); end
  endtask
  task automatic test_pop_push();
    for (int k = 0; k < 2; k++) begin
      drive(64'h2200, ADDI, JAL1);
      checks++; if (ras_push !== 1'b1) begin failures++; $display("FAIL pp_call%0d got=%b exp=1", k, ras_push); end
    end
    ras_top = 64'hABC0;
    drive(64'h3000, ADDI, JR15);
    checks++; if ({ras_push, ras_pop} !== 2'b11) begin failures++; $display("FAIL pp_strobes got=%b exp=11", {ras_push, ras_pop}); end
    checks++; if (ras_data !== 64'h3004) begin failures++; $display("FAIL pp_data got=%h exp=3004", ras_data); end
    settle();
    checks++; if ({pred_vld, pred_taken, pred_call} !== 3'b111) begin failures++; $display("FAIL pp_record got=%b exp=111", {pred_vld, pred_taken, pred_call}); end
    checks++; if (pred_target !== 64'hABC0) begin failures++; $display("FAIL pp_target got=%h exp=abc0", pred_target); end
    checks++; if (dut.count !== 3'd2) begin failures++; $display("FAIL pp_count got=%0d exp=2", dut.count); end
  endtask
  task automatic test_decode();
    drive(64'h3100, ADDI, JR11);
    checks++; if ({ras_push, ras_pop} !== 2'b10) begin failures++; $display("FAIL same_link got=%b exp=10", {ras_push, ras_pop}); end
    drive(64'h3200, JAL1, JRF3);
    checks++; if ({ras_push, ras_pop} !== 2'b10) begin failures++; $display("FAIL f3_skip got=%b exp=10", {ras_push, ras_pop}); end
    checks++; if (ras_data !== 64'h3208) begin failures++; $display("FAIL f3_data got=%h exp=3208", ras_data); end
    drive(64'h3300, JAL1, JAL0);
    checks++; if ({ras_push, ras_pop} !== 2'b00) begin failures++; $display("FAIL first_wins got=%b exp=00", {ras_push, ras_pop}); end
    drive(64'h3400, JAL0, ADDI);
    settle();
    checks++; if ({pred_vld, pred_slot, pred_call, pred_taken} !== 4'b1100) begin failures++; $display("FAIL jal0_record got=%b exp=1100", {pred_vld, pred_slot, pred_call, pred_taken}); end
    checks++; if (dut.count !== 3'd4) begin failures++; $display("FAIL decode_count got=%0d exp=4", dut.count); end
  endtask
  task automatic test_back_to_back();
    @(negedge clk);
    bp_flush = 1'b1;
    @(negedge clk);
    bp_flush = 1'b0;
    for (int k = 0; k < 5; k++) begin
      drive(64'h4000 + 64'(k) * 64'h100, ADDI, JAL1);
      checks++; if (dut.count !== 3'(k > 4 ? 4 : k)) begin failures++; $display("FAIL sat_count%0d got=%0d exp=%0d", k, dut.count, k); end
      checks++; if ({fetch_rdy, ras_push} !== 2'b11) begin failures++; $display("FAIL sat_push%0d got=%b exp=11", k, {fetch_rdy, ras_push}); end
      checks++; if (ras_data !== 64'h4004 + 64'(k) * 64'h100) begin failures++; $display("FAIL sat_data%0d got=%h", k, ras_data); end
    end
    pred_rdy = 1'b0;
    drive(64'h5000, ADDI, JAL1);
    for (int k = 0; k < 3; k++) begin
      checks++; if ({fetch_rdy, ras_push} !== 2'b00) begin failures++; $display("FAIL stall%0d got=%b exp=00", k, {fetch_rdy, ras_push}); end
      checks++; if ({pred_vld, pred_call, pred_slot, pred_taken} !== 4'b1100 || pred_target !== 64'h0) begin failures++; $display("FAIL hold%0d got=%b exp=1100", k, {pred_vld, pred_call, pred_slot, pred_taken}); end
      checks++; if (dut.count !== 3'd4) begin failures++; $display("FAIL sat_hold%0d got=%0d exp=4", k, dut.count); end
      @(negedge clk);
      #1;
    end
    pred_rdy = 1'b1;
    #1;
    checks++; if ({fetch_rdy, ras_push} !== 2'b11) begin failures++; $display("FAIL release got=%b exp=11", {fetch_rdy, ras_push}); end
    checks++; if (ras_data !== 64'h5004) begin failures++; $display("FAIL release_data got=%h exp=5004", ras_data); end
    settle();
    checks++; if (dut.count !== 3'd4) begin failures++; $display("FAIL sat_final got=%0d exp=4", dut.count); end
  endtask
  task automatic test_flush();
    @(negedge clk);
    fetch_instr = {ADDI, RET};
    fetch_vld = 1'b1;
    bp_flush = 1'b1;
    #1;
    checks++; if ({fetch_rdy, ras_push, ras_pop} !== 3'b000) begin failures++; $display("FAIL flush_strobes got=%b exp=000", {fetch_rdy, ras_push, ras_pop}); end
    checks++; if (pred_vld !== 1'b1) begin failures++; $display("FAIL flush_pre_vld got=%b exp=1", pred_vld); end
    settle();
    bp_flush = 1'b0;
    checks++; if (pred_vld !== 1'b0) begin failures++; $display("FAIL flush_vld got=%b exp=0", pred_vld); end
    checks++; if (dut.count !== 3'd0) begin failures++; $display("FAIL flush_count got=%0d exp=0", dut.count); end
  endtask
  task automatic test_mid_reset();
    drive(64'h6000, ADDI, JAL1);
    settle();
    @(negedge clk);
    fetch_vld = 1'b1;
    rst_n = 1'b0;
    #1;
    checks++; if ({ras_push, ras_pop, pred_vld} !== 3'b000) begin failures++; $display("FAIL midrst got=%b exp=000", {ras_push, ras_pop, pred_vld}); end
    checks++; if (dut.count !== 3'd0) begin failures++; $display("FAIL midrst_count got=%0d exp=0", dut.count); end
    fetch_vld = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask
  initial begin
    test_reset();
    test_call();
    test_return();
    test_underflow();
    test_pop_push();
    test_decode();
    test_back_to_back();
    test_flush();
    test_mid_reset();
    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/ras_ctrl.md
Name: ras_ctrl

Overview:
- Front end of the return address stack. Sits between fetch and the RAS storage block.
- Pre-decodes each accepted fetch packet for RISC-V calls and returns.
- Drives the push, pop and return-address write interface of the RAS, and consumes the RAS top-of-stack output.
- Emits one registered return-prediction record per packet to the branch-predictor redirect logic.

Parameters:
- DATA_WIDTH, 64, PC and return-address width.
- DATA_DEPTH, 4, number of RAS entries; bounds the occupancy counter.
- FETCH_WIDTH, 2, number of 32-bit instruction slots per fetch packet (power of two, >=2).

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- bp_flush_i  in  1  predictor flush
- fetch_vld_i  in  1  fetch packet valid
- fetch_rdy_o  out  1  packet accepted when vld&&rdy
- fetch_pc_i  in  DATA_WIDTH  PC of slot 0
- fetch_instr_i  in  32*FETCH_WIDTH  slot i at bits [32i+31:32i]
- ras_push_o  out  1  push request to RAS
- ras_pop_o  out  1  pop request to RAS
- ras_data_o  out  DATA_WIDTH  return address to push
- ras_data_vld_i  in  1  RAS top entry valid
- ras_data_i  in  DATA_WIDTH  RAS top entry
- pred_vld_o  out  1  prediction record valid
- pred_rdy_i  in  1  consumer ready
- pred_taken_o  out  1  return predicted, target valid
- pred_target_o  out  DATA_WIDTH  predicted return target
- pred_slot_o  out  max(1,$clog2(FETCH_WIDTH))  slot of the first jump
- pred_call_o  out  1  packet's first jump was a push-type op

Behaviour:
- Reset is asynchronous and active-low. Reset state: pred_vld_o=0, pred_taken_o=0, pred_call_o=0, pred_target_o=0, pred_slot_o=0, occupancy count=0. ras_push_o and ras_pop_o are 0 during reset.
- Link registers are x1 and x5.
- Decode scans slots in ascending order; the first slot holding JAL (opcode 1101111) or JALR (opcode 1100111, funct3 000) is selected. Later slots are ignored. Non-jump packets perform no RAS op.
- RAS operation for the selected jump:
  - JAL with rd=link: push.
  - JALR, rd=link, rs1 not link: push.
  - JALR, rd not link, rs1=link: pop.
  - JALR, rd=link, rs1=link, rd!=rs1: pop and push in the same cycle.
  - JALR, rd=link, rs1=link, rd==rs1: push.
  - All other cases: none.
- Push address: ras_data_o = fetch_pc_i + 4*slot, + 4, truncated to DATA_WIDTH.
- Handshake: fetch_rdy_o = !bp_flush_i && (!pred_vld_o || pred_rdy_i).
- RAS strobes: ras_push_o and ras_pop_o are combinational, asserted only in the acceptance cycle. Each is exactly one cycle per accepted packet. Both are zero whenever bp_flush_i=1.
- Pop gating: a pop is issued only if count>0. At count==0 it is suppressed; pred_taken=0, and a pop+push case degrades to push only.
- Result capture: in the acceptance cycle ras_data_i and ras_data_vld_i (the pre-pop top) are sampled. At the next edge they are registered as:
  - pred_taken = pop issued && ras_data_vld_i
  - pred_target = ras_data_i when taken, else 0
- Output register:
  - Latency is exactly 1 cycle from acceptance to pred_vld_o.
  - Every accepted packet produces a record, including non-jump packets (taken=0, slot=0, call=0).
  - The record is held stable while pred_vld_o && !pred_rdy_i.
  - Back-to-back throughput is 1 packet/cycle when pred_rdy_i=1.
- Occupancy counter, range 0..DATA_DEPTH:
  - Push only: +1, saturating at DATA_DEPTH. The push is still issued at saturation; the RAS drops its oldest entry.
  - Pop only: -1.
  - Pop+push: unchanged.
- Flush: bp_flush_i=1 clears pred_vld_o and count to 0 at the next edge and blocks acceptance. The flush takes priority over simultaneous pred_rdy_i or fetch_vld_i.
- Reset asserted mid-operation clears all state immediately; no strobe glitches while rst_ni=0.

Test Plan:
1. Reset, then a packet with pc=0x1000 and slot0=JAL x1,+0x100 -> ras_push_o=1 and ras_data_o=0x1004 in the acceptance cycle; next cycle pred_vld_o=1, pred_call_o=1, pred_slot_o=0, pred_taken_o=0; count=1.
2. With count=1 and RAS top 0x1004 valid, a packet with pc=0x2000, slot0=ADDI, slot1=JALR x0,0(x1) -> ras_pop_o=1; next cycle pred_taken_o=1, pred_target_o=0x1004, pred_slot_o=1; count=0.
3. Count=0, packet holding a return (JALR x0,0(x1)) -> ras_pop_o=0; record has pred_taken_o=0; count stays 0.
4. Count=2, packet with pc=0x3000 and slot0=JALR x1,0(x5) -> pop and push in the same cycle, ras_data_o=0x3004; pred_taken_o=1 with the captured top; count=2.
5. Five consecutive calls with DATA_DEPTH=4 -> five push pulses; count saturates at 4. Hold pred_rdy_i=0 for 3 cycles -> fetch_rdy_o=0, the record is held stable, and no extra push is issued.
6. bp_flush_i pulsed while pred_vld_o=1 and fetch_vld_i=1 -> no strobes that cycle, fetch_rdy_o=0; next cycle pred_vld_o=0 and count=0.
